cin_word_aligner: RTL

- Sits directly downstream of the TURF CIN ISERDES (4-bit, DDR, rxclk domain).
- Assembles the nibble stream into 32-bit words.
- Trains autonomously against the fixed CIN training pattern: finds the nibble-to-word boundary and requests ISERDES bitslips until the bit alignment is correct.
- After training, delivers aligned 32-bit command words with a valid strobe to the downstream command decoder.

---
 rtl/cin_word_aligner_if.sv | 23 ++
 rtl/cin_word_aligner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cin_word_aligner_if.sv
// CIN aligner bus: ISERDES nibbles and training control in, aligned words and
// training status out. The slave side is the aligner itself.
interface cin_word_aligner_if;
  logic [3:0]  cin_parallel_i;
  logic        train_en_i;
  logic        bitslip_o;
  logic        locked_o;
  logic        fail_o;
  logic [1:0]  slip_count_o;
  logic [31:0] dat_o;
  logic        dat_valid_o;
  logic [15:0] err_count_o;

  modport master (
    output cin_parallel_i, train_en_i,
    input  bitslip_o, locked_o, fail_o, slip_count_o, dat_o, dat_valid_o, err_count_o
  );

  modport slave (
    input  cin_parallel_i, train_en_i,
    output bitslip_o, locked_o, fail_o, slip_count_o, dat_o, dat_valid_o, err_count_o
  );
endinterface

// File: rtl/cin_word_aligner.sv
// CIN word aligner: assembles ISERDES nibbles into 32-bit words, trains the
// nibble boundary and bit alignment against the CIN pattern, then delivers words.
module cin_word_aligner #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int          HUNT_CYCLES   = 64,
  parameter int          SLIP_WAIT     = 4,
  parameter int          LOCK_MATCHES  = 16
) (
  input logic           rxclk_i,
  input logic           rst_n_i,
  cin_word_aligner_if.slave cin_bus
);

  localparam int TW = (HUNT_CYCLES > 1) ? $clog2(HUNT_CYCLES) : 1;
  localparam int WW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam int MW = $clog2(LOCK_MATCHES + 1);

  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HUNT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_ZERO  = WW'(0);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT);
  localparam logic [MW-1:0] MATCH_ZERO = MW'(0);
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HUNT      = 3'd1,
    ST_SLIP_WAIT = 3'd2,
    ST_CHECK     = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  state_e      state_r;
  logic [31:0] sr_r;
  logic [2:0]  phase_r;
  logic        train_en_q_r;
  logic [TW-1:0] timer_r;
  logic [WW-1:0] wait_r;
  logic [MW-1:0] match_r;
  logic [1:0]  slip_count_r;
  logic        bitslip_r;
  logic        locked_r;
  logic        fail_r;
  logic [31:0] dat_r;
  logic        dat_valid_r;
  logic [15:0] err_count_r;

  logic rise_s;
  logic match_s;
  logic boundary_s;

  assign rise_s     = cin_bus.train_en_i & ~train_en_q_r;
  assign match_s    = (sr_r == TRAIN_PATTERN);
  assign boundary_s = (phase_r == 3'd0);

  // Nibble shift register: the oldest nibble ends up in sr_r[3:0]
  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_r <= 32'h0000_0000;
    end else begin
      sr_r <= {cin_bus.cin_parallel_i, sr_r[31:4]};
    end
  end

  // Training state machine, phase counter and all registered outputs
  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      phase_r      <= 3'd0;
      train_en_q_r <= 1'b0;
      timer_r      <= TIMER_ZERO;
      wait_r       <= WAIT_ZERO;
      match_r      <= MATCH_ZERO;
      slip_count_r <= 2'd0;
      bitslip_r    <= 1'b0;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
      dat_r        <= 32'h0000_0000;
      dat_valid_r  <= 1'b0;
      err_count_r  <= 16'h0000;
    end else begin
      train_en_q_r <= cin_bus.train_en_i;
      phase_r      <= phase_r + 3'd1;
      bitslip_r    <= 1'b0;
      dat_valid_r  <= 1'b0;
      if (rise_s) begin
        state_r      <= ST_HUNT;
        slip_count_r <= 2'd0;
        timer_r      <= TIMER_ZERO;
        match_r      <= MATCH_ZERO;
        err_count_r  <= 16'h0000;
        locked_r     <= 1'b0;
        fail_r       <= 1'b0;
      end else if (!cin_bus.train_en_i && (state_r != ST_LOCKED)) begin
        state_r  <= ST_IDLE;
        locked_r <= 1'b0;
        fail_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_HUNT: begin
            // A match beats a timeout; realign the phase so the next boundary is 8 cycles out
            if (match_s) begin
              state_r <= ST_CHECK;
              match_r <= MATCH_ONE;
              phase_r <= 3'd1;
            end else if (timer_r == TIMER_LAST) begin
              if (slip_count_r == 2'd3) begin
                state_r <= ST_FAIL;
                fail_r  <= 1'b1;
              end else begin
                state_r      <= ST_SLIP_WAIT;
                bitslip_r    <= 1'b1;
                slip_count_r <= slip_count_r + 2'd1;
                wait_r       <= WAIT_ZERO;
              end
            end else begin
              timer_r <= timer_r + TIMER_ONE;
            end
          end
          ST_SLIP_WAIT: begin
            if (wait_r == WAIT_LAST) begin
              state_r <= ST_HUNT;
              timer_r <= TIMER_ZERO;
            end else begin
              wait_r <= wait_r + WAIT_ONE;
            end
          end
          ST_CHECK: begin
            if (boundary_s) begin
              if (!match_s) begin
                state_r <= ST_HUNT;
                timer_r <= TIMER_ZERO;
              end else if (match_r == MATCH_LAST) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
              end else begin
                match_r <= match_r + MATCH_ONE;
              end
            end else begin
              match_r <= match_r;
            end
          end
          ST_LOCKED: begin
            if (boundary_s) begin
              dat_r       <= sr_r;
              dat_valid_r <= 1'b1;
              if (cin_bus.train_en_i && !match_s && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
              end else begin
                err_count_r <= err_count_r;
              end
            end else begin
              dat_r <= dat_r;
            end
          end
          ST_FAIL: begin
            state_r <= ST_FAIL;
          end
          default: begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
            fail_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cin_bus.bitslip_o    = bitslip_r;
  assign cin_bus.locked_o     = locked_r;
  assign cin_bus.fail_o       = fail_r;
  assign cin_bus.slip_count_o = slip_count_r;
  assign cin_bus.dat_o        = dat_r;
  assign cin_bus.dat_valid_o  = dat_valid_r;
  assign cin_bus.err_count_o  = err_count_r;

endmodule
